l2_banked_spm: RTL and testbench



---
 rtl/l2_banked_spm_if.sv | 28 ++
 rtl/l2_banked_spm.sv | 178 +++++++++++++++++
 tb/tb_l2_banked_spm.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/l2_banked_spm_if.sv
// Bus bundle for the banked L2 scratchpad: one TCDM request/response
// channel per master port, packed port-major.
interface l2_banked_spm_if #(
    parameter int NUM_PORTS  = 6,
    parameter int DATA_WIDTH = 32
) ();

    logic [NUM_PORTS-1:0]                     req_i;
    logic [NUM_PORTS-1:0][31:0]               add_i;
    logic [NUM_PORTS-1:0]                     wen_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i;
    logic [NUM_PORTS-1:0]                     gnt_o;
    logic [NUM_PORTS-1:0]                     r_valid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     r_rdata_o;
    logic [NUM_PORTS-1:0]                     r_opc_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

endinterface

// File: rtl/l2_banked_spm.sv
// Multi-port L2 scratchpad: per-port base rebasing, word-interleaved
// single-port banks with per-bank round-robin arbitration, error
// responses for out-of-range accesses and a configurable read latency.
module l2_banked_spm #(
    parameter int NUM_PORTS  = 6,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WORDS = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter logic [NUM_PORTS-1:0][31:0] PORT_BASE = {NUM_PORTS{32'h1C00_0000}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    l2_banked_spm_if.slave   bus,
    output logic [15:0]      err_cnt_o
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(BE_W);
    localparam int BANK_SH = $clog2(NUM_BANKS);
    localparam int BANK_W  = (NUM_BANKS > 1) ? BANK_SH : 1;
    localparam int ROW_W   = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [63:0] SPAN = 64'(NUM_BANKS) * 64'(BANK_WORDS) * 64'(BE_W);

    logic [NUM_PORTS-1:0][31:0]          w_off;
    logic [NUM_PORTS-1:0][31:0]          w_word;
    logic [NUM_PORTS-1:0][BANK_W-1:0]    w_bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]     w_row;
    logic [NUM_PORTS-1:0]                w_inRange;
    logic [NUM_PORTS-1:0]                w_oorReq;
    logic [NUM_PORTS-1:0]                w_arbGnt;

    logic [NUM_BANKS-1:0]                w_bankAny;
    logic [NUM_BANKS-1:0][PORT_W-1:0]    w_bankWin;
    logic [NUM_BANKS-1:0][PORT_W-1:0]    r_ptr;
    logic [NUM_BANKS-1:0]                w_bankWr;
    logic [NUM_BANKS-1:0]                w_bankRd;
    logic [NUM_BANKS-1:0][ROW_W-1:0]     w_bankRow;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bankWdata;
    logic [NUM_BANKS-1:0][BE_W-1:0]      w_bankBe;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bankOut;

    logic [NUM_PORTS-1:0]                r_pValid [RD_LAT];
    logic [NUM_PORTS-1:0]                r_pOpc   [RD_LAT];
    logic [NUM_PORTS-1:0]                r_pRead  [RD_LAT];
    logic [NUM_PORTS-1:0][BANK_W-1:0]    r_pBank  [RD_LAT];

    logic [15:0]                         r_errCnt;
    logic [16:0]                         w_errSum;

    // Rebase each port's address and split it into bank / row / range flag.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_off[p]     = bus.add_i[p] - PORT_BASE[p];
            w_word[p]    = w_off[p] >> BYTE_SH;
            w_bank[p]    = BANK_W'(w_word[p] & 32'(NUM_BANKS - 1));
            w_row[p]     = ROW_W'(w_word[p] >> BANK_SH);
            w_inRange[p] = ({32'd0, w_off[p]} < SPAN);
            w_oorReq[p]  = bus.req_i[p] & ~w_inRange[p];
        end
    end

    // Per-bank round-robin search starting at the bank's pointer.
    always_comb begin
        int idx;
        w_bankAny = '0;
        w_bankWin = '0;
        w_arbGnt  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(r_ptr[b]) + k) % NUM_PORTS;
                if (!w_bankAny[b] && bus.req_i[idx] && w_inRange[idx] &&
                    (int'(w_bank[idx]) == b)) begin
                    w_bankAny[b] = 1'b1;
                    w_bankWin[b] = PORT_W'(idx);
                    w_arbGnt[idx] = 1'b1;
                end
            end
        end
    end

    // Out-of-range requests bypass the banks and are granted immediately.
    assign bus.gnt_o = w_arbGnt | w_oorReq;

    // Steer the winning port's command onto its bank.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bankRow[b]   = w_row[w_bankWin[b]];
            w_bankWdata[b] = bus.wdata_i[w_bankWin[b]];
            w_bankBe[b]    = bus.be_i[w_bankWin[b]];
            w_bankWr[b]    = w_bankAny[b] & ~bus.wen_i[w_bankWin[b]];
            w_bankRd[b]    = w_bankAny[b] &  bus.wen_i[w_bankWin[b]];
        end
    end

    // Advance each bank pointer past its winner; idle banks hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bankAny[b]) begin
                    if (int'(w_bankWin[b]) == NUM_PORTS - 1) r_ptr[b] <= '0;
                    else                                      r_ptr[b] <= w_bankWin[b] + PORT_W'(1);
                end
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem    [BANK_WORDS];
        logic [DATA_WIDTH-1:0] r_rdPipe [RD_LAT];

        // Byte-masked SRAM write, registered read, then RD_LAT-1 delay stages.
        always_ff @(posedge clk_i) begin
            if (w_bankWr[gb]) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (w_bankBe[gb][i]) r_mem[w_bankRow[gb]][i*8 +: 8] <= w_bankWdata[gb][i*8 +: 8];
                end
            end
            if (w_bankRd[gb]) r_rdPipe[0] <= r_mem[w_bankRow[gb]];
            for (int s = 1; s < RD_LAT; s++) r_rdPipe[s] <= r_rdPipe[s-1];
        end

        assign w_bankOut[gb] = r_rdPipe[RD_LAT-1];
    end

    // Per-port response pipeline tracking which grants owe a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_pValid[s] <= '0;
                r_pOpc[s]   <= '0;
                r_pRead[s]  <= '0;
                r_pBank[s]  <= '0;
            end
        end else begin
            r_pValid[0] <= bus.gnt_o;
            r_pOpc[0]   <= w_oorReq;
            r_pRead[0]  <= w_arbGnt & bus.wen_i;
            r_pBank[0]  <= w_bank;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pValid[s] <= r_pValid[s-1];
                r_pOpc[s]   <= r_pOpc[s-1];
                r_pRead[s]  <= r_pRead[s-1];
                r_pBank[s]  <= r_pBank[s-1];
            end
        end
    end

    // Response mux: only in-range reads carry bank data.
    always_comb begin
        bus.r_valid_o = r_pValid[RD_LAT-1];
        bus.r_opc_o   = r_pValid[RD_LAT-1] & r_pOpc[RD_LAT-1];
        bus.r_rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_pValid[RD_LAT-1][p] && r_pRead[RD_LAT-1][p])
                bus.r_rdata_o[p] = w_bankOut[r_pBank[RD_LAT-1][p]];
        end
    end

    // Sum this cycle's out-of-range grants onto the error count.
    always_comb begin
        w_errSum = {1'b0, r_errCnt};
        for (int p = 0; p < NUM_PORTS; p++) w_errSum = w_errSum + 17'(w_oorReq[p]);
    end

    // Saturating out-of-range counter.
    always_ff @(posedge clk_i) begin
        if (rst_i)            r_errCnt <= '0;
        else if (w_errSum[16]) r_errCnt <= 16'hFFFF;
        else                  r_errCnt <= w_errSum[15:0];
    end

    assign err_cnt_o = r_errCnt;

endmodule

// File: tb/tb_l2_banked_spm.sv
// Directed bench for l2_banked_spm: a RD_LAT=1 instance checked through a
// response scoreboard, plus a RD_LAT=3 instance for latency and reset drop.
module tb_l2_banked_spm;

    localparam logic [31:0] B = 32'h1C00_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          due;
    } resp_t;

    logic        clk  = 1'b0;
    logic        rst1 = 1'b1;
    logic        rst3 = 1'b1;
    logic [15:0] err1;
    logic [15:0] err3;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    resp_t       q1 [6][$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    // Cycle counter used to stamp when each response is due.
    always @(posedge clk) cyc <= cyc + 1;

    l2_banked_spm_if #(.NUM_PORTS(6), .DATA_WIDTH(32)) bus1 ();
    l2_banked_spm_if #(.NUM_PORTS(6), .DATA_WIDTH(32)) bus3 ();

    l2_banked_spm #(.NUM_PORTS(6), .NUM_BANKS(4), .BANK_WORDS(32768),
                    .DATA_WIDTH(32), .RD_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .bus(bus1), .err_cnt_o(err1));

    l2_banked_spm #(.NUM_PORTS(6), .NUM_BANKS(4), .BANK_WORDS(256),
                    .DATA_WIDTH(32), .RD_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .bus(bus3), .err_cnt_o(err3));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle1();
        bus1.req_i = '0; bus1.add_i = '0; bus1.wen_i = '0; bus1.wdata_i = '0; bus1.be_i = '0;
    endtask

    task automatic idle3();
        bus3.req_i = '0; bus3.add_i = '0; bus3.wen_i = '0; bus3.wdata_i = '0; bus3.be_i = '0;
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] addr, input logic wen,
                                 input logic [31:0] wdata, input logic [3:0] be);
        bus1.req_i[p] = 1'b1; bus1.add_i[p] = addr; bus1.wen_i[p] = wen;
        bus1.wdata_i[p] = wdata; bus1.be_i[p] = be;
    endtask

    task automatic applyStimulus3(input int p, input logic [31:0] addr, input logic wen,
                                  input logic [31:0] wdata);
        bus3.req_i[p] = 1'b1; bus3.add_i[p] = addr; bus3.wen_i[p] = wen;
        bus3.wdata_i[p] = wdata; bus3.be_i[p] = 4'hF;
    endtask

    // Reference behaviour of one granted access: expected response and memory update.
    task automatic pushExpected(input int p);
        resp_t       e;
        logic [31:0] off, w, old;
        off = bus1.add_i[p] - B;
        e.due = cyc + 1; e.rdata = 32'h0; e.opc = 1'b0;
        if (off >= 32'h0008_0000) begin
            e.opc = 1'b1;
        end else begin
            w = off >> 2;
            old = model.exists(int'(w)) ? model[int'(w)] : 32'h0;
            if (bus1.wen_i[p]) begin
                e.rdata = old;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (bus1.be_i[p][i]) old[i*8 +: 8] = bus1.wdata_i[p][i*8 +: 8];
                model[int'(w)] = old;
            end
        end
        q1[p].push_back(e);
    endtask

    task automatic stepCycle(input string tag, input logic [5:0] expGnt);
        #3;
        checkOutput({tag, " gnt"}, 32'(bus1.gnt_o), 32'(expGnt));
        for (int p = 0; p < 6; p++) if (expGnt[p]) pushExpected(p);
        @(posedge clk); #1;
    endtask

    task automatic step3(input string tag, input logic [5:0] expGnt,
                         input logic [5:0] expValid, input logic [31:0] expData0);
        #3;
        checkOutput({tag, " gnt"},    32'(bus3.gnt_o),     32'(expGnt));
        checkOutput({tag, " valid"},  32'(bus3.r_valid_o), 32'(expValid));
        checkOutput({tag, " rdata0"}, bus3.r_rdata_o[0],   expData0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: pop each port's expected response on its due cycle.
    always @(negedge clk) begin
        for (int p = 0; p < 6; p++) begin
            if (q1[p].size() > 0 && q1[p][0].due == cyc) begin
                resp_t e;
                e = q1[p].pop_front();
                checkOutput($sformatf("p%0d valid", p), 32'(bus1.r_valid_o[p]), 32'h1);
                checkOutput($sformatf("p%0d rdata", p), bus1.r_rdata_o[p], e.rdata);
                checkOutput($sformatf("p%0d opc", p),   32'(bus1.r_opc_o[p]), 32'(e.opc));
            end else if (bus1.r_valid_o[p]) begin
                checkOutput($sformatf("p%0d spurious valid", p), 32'(bus1.r_valid_o[p]), 32'h0);
            end
        end
    end

    initial begin
        idle1(); idle3();
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0; rst3 = 1'b0;

        checkOutput("rst err1",   32'(err1), 32'h0);
        checkOutput("rst valid1", 32'(bus1.r_valid_o), 32'h0);
        checkOutput("rst opc1",   32'(bus1.r_opc_o), 32'h0);
        checkOutput("rst rdata1", 32'(|bus1.r_rdata_o), 32'h0);
        checkOutput("rst err3",   32'(err3), 32'h0);
        checkOutput("rst valid3", 32'(bus3.r_valid_o), 32'h0);

        // Single-port write then read back
        applyStimulus(0, B + 32'h10, 1'b0, 32'hDEADBEEF, 4'hF); stepCycle("wr10", 6'h01);
        idle1(); applyStimulus(0, B + 32'h10, 1'b1, 32'h0, 4'h0); stepCycle("rd10", 6'h01);
        idle1(); stepCycle("idle", 6'h00); stepCycle("idle", 6'h00);

        // Byte enables, read-after-write on the next cycle
        applyStimulus(0, B, 1'b0, 32'h11223344, 4'hF); stepCycle("be wr1", 6'h01);
        idle1(); applyStimulus(0, B, 1'b0, 32'hAABBCCDD, 4'b0101); stepCycle("be wr2", 6'h01);
        idle1(); applyStimulus(0, B, 1'b1, 32'h0, 4'h0); stepCycle("be rd", 6'h01);
        idle1(); stepCycle("idle", 6'h00);
        checkOutput("be model", model[0], 32'h11BB33DD);

        // Preload data for the contention and parallel-bank tests
        applyStimulus(0, B + 32'h20, 1'b0, 32'h55667788, 4'hF); stepCycle("wr20", 6'h01);
        idle1();
        for (int i = 0; i < 4; i++) applyStimulus(i, B + 32'h40 + 32'(4*i), 1'b0, 32'hA000_0000 + 32'(i), 4'hF);
        stepCycle("par wr", 6'h0F);
        idle1(); stepCycle("idle", 6'h00); stepCycle("idle", 6'h00);

        // Reset to bring the arbiter pointers back to port 0
        rst1 = 1'b1; stepCycle("rst", 6'h00); rst1 = 1'b0;
        checkOutput("rst2 err1", 32'(err1), 32'h0);

        // Contention on bank 0 from ports 0, 2, 5
        applyStimulus(0, B,          1'b1, 32'h0, 4'h0);
        applyStimulus(2, B + 32'h10, 1'b1, 32'h0, 4'h0);
        applyStimulus(5, B + 32'h20, 1'b1, 32'h0, 4'h0);
        stepCycle("rr1", 6'h01); stepCycle("rr2", 6'h04); stepCycle("rr3", 6'h20);
        stepCycle("rr4", 6'h01); stepCycle("rr5", 6'h04); stepCycle("rr6", 6'h20);
        idle1(); stepCycle("idle", 6'h00); stepCycle("idle", 6'h00);

        // Four banks in parallel
        for (int i = 1; i <= 4; i++) applyStimulus(i, B + 32'h40 + 32'(4*(i-1)), 1'b1, 32'h0, 4'h0);
        stepCycle("par rd", 6'h1E);
        idle1(); stepCycle("idle", 6'h00); stepCycle("idle", 6'h00);

        // Out of range below and above the window
        applyStimulus(0, B - 32'h4, 1'b1, 32'h0, 4'h0); stepCycle("oor lo", 6'h01);
        idle1(); applyStimulus(3, B + 32'h0008_0000, 1'b0, 32'h12345678, 4'hF); stepCycle("oor hi", 6'h08);
        idle1();
        checkOutput("oor err1", 32'(err1), 32'h2);
        applyStimulus(0, B, 1'b1, 32'h0, 4'h0); stepCycle("no alias", 6'h01);
        idle1(); stepCycle("idle", 6'h00);

        // Drive the counter into saturation with all ports out of range
        for (int p = 0; p < 6; p++) applyStimulus(p, B - 32'h4, 1'b1, 32'h0, 4'h0);
        for (int i = 0; i < 100; i++) stepCycle("sat", 6'h3F);
        checkOutput("err1 602", 32'(err1), 32'd602);
        for (int i = 0; i < 10830; i++) stepCycle("sat", 6'h3F);
        checkOutput("err1 sat", 32'(err1), 32'hFFFF);
        stepCycle("sat", 6'h3F);
        checkOutput("err1 hold", 32'(err1), 32'hFFFF);
        idle1(); stepCycle("idle", 6'h00); stepCycle("idle", 6'h00);

        // RD_LAT=3: write then read, response three cycles after each grant
        applyStimulus3(0, B + 32'h8, 1'b0, 32'hCAFEF00D); step3("l3 wr", 6'h01, 6'h00, 32'h0);
        idle3(); applyStimulus3(0, B + 32'h8, 1'b1, 32'h0); step3("l3 rd", 6'h01, 6'h00, 32'h0);
        idle3();
        step3("l3 c2", 6'h00, 6'h00, 32'h0);
        step3("l3 c3", 6'h00, 6'h01, 32'h0);
        step3("l3 c4", 6'h00, 6'h01, 32'hCAFEF00D);
        step3("l3 c5", 6'h00, 6'h00, 32'h0);

        // Reset while a read and an error response are in flight
        applyStimulus3(0, B + 32'h8, 1'b1, 32'h0);
        applyStimulus3(1, B - 32'h4, 1'b1, 32'h0);
        step3("l3 d0", 6'h03, 6'h00, 32'h0);
        idle3();
        checkOutput("l3 err 1", 32'(err3), 32'h1);
        step3("l3 d1", 6'h00, 6'h00, 32'h0);
        rst3 = 1'b1; step3("l3 d2", 6'h00, 6'h00, 32'h0); rst3 = 1'b0;
        checkOutput("l3 err 0", 32'(err3), 32'h0);
        for (int i = 0; i < 4; i++) step3("l3 drop", 6'h00, 6'h00, 32'h0);

        // Pointer must restart at port 0 after the reset
        applyStimulus3(0, B + 32'h8, 1'b1, 32'h0);
        applyStimulus3(1, B + 32'h8, 1'b1, 32'h0);
        step3("l3 e0", 6'h01, 6'h00, 32'h0);
        bus3.req_i[0] = 1'b0;
        step3("l3 e1", 6'h02, 6'h00, 32'h0);
        idle3();
        step3("l3 e2", 6'h00, 6'h00, 32'h0);
        step3("l3 e3", 6'h00, 6'h01, 32'hCAFEF00D);
        step3("l3 e4", 6'h00, 6'h02, 32'h0);

        for (int p = 0; p < 6; p++)
            checkOutput($sformatf("p%0d drained", p), 32'(q1[p].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
